// File: rtl/fifo_pkg.sv
// Shared defaults, pause-state encoding and log2 helper for the parameterised FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W_DEF = 6;
  localparam int unsigned FIFO_DEPTH_DEF  = 8;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pause_state_e;

  // Ceiling log2, usable in constant expressions for address widths.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: DEPTH x DATA_W array with one synchronous write port and a registered read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W_DEF,
  parameter int unsigned DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned ADDR_W = log2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array itself is never reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register samples the pre-write value, so a full-FIFO read+write is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with threshold flags, pause hysteresis and error reporting.
// Define FIFO_STICKY_ERR_EN to hold err_fifo high after the first error until reset.
module fifo_param
  import fifo_pkg::*;
#(
  parameter  int unsigned DATA_W = FIFO_DATA_W_DEF,
  parameter  int unsigned DEPTH  = FIFO_DEPTH_DEF,
  localparam int unsigned ADDR_W = log2(DEPTH),
  localparam int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              RESET_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_wr,
  input  logic              fifo_rd,
  input  logic [CNT_W-1:0]  al_empty_in,
  input  logic [CNT_W-1:0]  al_full_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              al_empty,
  output logic              al_full,
  output logic              pause,
  output logic              err_fifo,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt_c;
  logic              rd_accept_c;
  logic              wr_accept_c;
  logic              err_event_c;
  logic              thr_ok_c;
  pause_state_e      state;
  pause_state_e      state_nxt;

  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  assign rd_accept_c = fifo_rd && (count != '0);
  assign wr_accept_c = fifo_wr && ((count != CNT_FULL) || rd_accept_c);
  assign err_event_c = (fifo_wr && !wr_accept_c) || (fifo_rd && !rd_accept_c);

  always_comb begin
    count_nxt_c = count;
    unique case ({wr_accept_c, rd_accept_c})
      2'b10:   count_nxt_c = count + CNT_W'(1);
      2'b01:   count_nxt_c = count - CNT_W'(1);
      default: count_nxt_c = count;
    endcase
  end

  // Pointers roll over naturally at ADDR_W bits.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_accept_c) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count <= count_nxt_c;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (RESET_L),
    .wr_en   (wr_accept_c),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_accept_c),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_accept_c;
    end
  end

`ifdef FIFO_STICKY_ERR_EN
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      err_fifo <= 1'b0;
    end else if (err_event_c) begin
      err_fifo <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      err_fifo <= 1'b0;
    end else begin
      err_fifo <= err_event_c;
    end
  end
`endif

  // Pause hysteresis state register.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Thresholds that do not leave a hysteresis band keep the FSM in RUN.
  assign thr_ok_c = (al_full_in > al_empty_in);

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (thr_ok_c && (count_nxt_c >= al_full_in)) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!thr_ok_c || (count_nxt_c <= al_empty_in)) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign pause      = (state == HOLD);
  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);
  assign al_full    = (count >= al_full_in);
  assign al_empty   = (count <= al_empty_in);

endmodule
